neo_video_out: RTL and testbench
================================

Name: neo_video_out

Overview:
Parametrised pixel output stage for the Neo-Geo video path. Sits after NEO-B1 and the palette RAM and replaces the fixed combinational palette-to-RGB conversion. Registers and converts palette words to RGB of configurable width, applies shadow and blanking, and delays syncs to match the data latency. It also produces beam position counters and a per-line pixel count, used for scaler alignment and for checking the sync and async LSPC models against each other.

Parameters:
COLOR_W, 8, output bits per channel; legal range 6..11.
PIPE_STAGES, 1, extra output register stages after conversion; legal range 0..4.
POS_W, 9, width of HPOS, VPOS and LINE_PIXELS.

Ports:
CLK  in  1  system clock (48 MHz).
nRESET  in  1  asynchronous, active-low reset.
CLK_EN_PIX  in  1  pixel clock enable (6 MHz rate); all state except reset advances only when high.
PAL_DATA  in  16  palette RAM word: [15] dark, [14:12] R/G/B LSB, [11:8] R, [7:4] G, [3:0] B.
SHADOW  in  1  halve output intensity.
BLANK  in  1  force black; active high.
HSYNC_IN  in  1  horizontal sync, active low.
VSYNC_IN  in  1  vertical sync, active low.
RED, GREEN, BLUE  out  COLOR_W  channel outputs.
HSYNC, VSYNC  out  1  syncs delayed to match RGB.
DE  out  1  data enable: ~BLANK, delayed to match RGB.
HPOS  out  POS_W  pixel index within the current line.
VPOS  out  POS_W  line index within the current frame.
LINE_PIXELS  out  POS_W  pixel count of the previous complete line.

Behaviour:
- Reset values: RGB = 0; HSYNC = 1; VSYNC = 1; DE = 0; HPOS, VPOS and LINE_PIXELS = 0; all pipeline registers are cleared to the same idle state (RGB 0, syncs 1, DE 0).
- Stage 1, on CLK_EN_PIX: register PAL_DATA, SHADOW, BLANK, HSYNC_IN and VSYNC_IN.
- Stage 2, on CLK_EN_PIX: per-channel conversion, registered.
  - Form a 6-bit value c6 = {nibble, LSB bit, nibble[3]}, computed as a 7-bit quantity minus the dark bit.
  - If the subtraction underflows, c6 = 0 (clamp). c6 = 63 with dark set gives 62.
  - Expand to COLOR_W bits as {c6, c6[4 -: COLOR_W-6]}. For COLOR_W = 6 no bits are appended; for COLOR_W = 8 this is {c6, c6[4:3]}.
  - If SHADOW is set, the value is shifted right by 1 with the MSB forced to 0.
  - If BLANK is set, the output is 0. BLANK overrides SHADOW.
- PIPE_STAGES further registers follow, each advancing on CLK_EN_PIX.
- Total latency is 2 + PIPE_STAGES pixel enables, identical for RGB, HSYNC, VSYNC and DE.
- Outputs hold their value while CLK_EN_PIX is low.
- Counters work from the stage-1 registered syncs; a falling edge is detected by comparison with the previous enabled sample.
  - HSYNC falling edge: LINE_PIXELS <= HPOS + 1, then HPOS <= 0 and VPOS increments.
  - Otherwise HPOS increments on each enable and saturates at all-ones; it does not wrap.
  - VSYNC falling edge: VPOS <= 0. If it coincides with an HSYNC edge in the same enable, the VSYNC clear wins and the HSYNC-edge LINE_PIXELS update still occurs.
  - VPOS saturates at all-ones.
  - The first HSYNC edge after reset loads LINE_PIXELS with the partial count; this is accepted behaviour.
- Reset asserted mid-frame returns every register to its reset value immediately, regardless of CLK.
- After release the pipeline refills: outputs show idle values for 2 + PIPE_STAGES enables.
- Out-of-range parameters are rejected at elaboration by a generate-time check.

Decomposition:
- Package neo_video_pkg:
  - PAL_DARK_BIT = 15.
  - Bit-position constants for each channel's nibble and LSB.
  - Function pal_to_c6 (nibble, lsb, dark) returning the 6-bit clamped value.
  - Function expand_c6 (c6, width).
- Sub-module neo_color_chan: one channel's stage-2 logic (convert, expand, shadow, blank), instantiated three times.
- Sync/DE delay, pipeline and counters live in the top module.

Test Plan:
- COLOR_W=8, PIPE_STAGES=1: PAL_DATA 0x0F00 -> RED 0xF7, GREEN 0x00, BLUE 0x00 exactly 3 enables later; the held value is unchanged while CLK_EN_PIX is low.
- PAL_DATA 0x7FFF -> 0xFF/0xFF/0xFF; 0xFFFF -> 0xFB each channel; 0x8000 -> 0x00 (underflow clamp).
- 0x7FFF with SHADOW=1 -> 0x7F each channel; with SHADOW=1 and BLANK=1 -> 0x00 and DE=0. Sweep COLOR_W=6 (0x7FFF -> 0x3F) and COLOR_W=10 (0x7FFF -> 0x3FF).
- HSYNC_IN low for 1 enable every 384 enables: LINE_PIXELS = 384 after the second edge; HPOS wraps 383 -> 0; VPOS increments per line. HSYNC output is delayed exactly 2 + PIPE_STAGES enables.
- Coincident HSYNC and VSYNC falling edges in one enable -> VPOS = 0, LINE_PIXELS updated. Withholding HSYNC for 600 enables saturates HPOS at 511.
- Assert nRESET mid-line between clock edges -> RGB = 0, syncs = 1, DE = 0 and counters = 0 immediately. After release, idle values persist for 3 enables, then converted data appears.

Source files
------------

// File: rtl/neo_video_pkg.sv
// Shared constants and palette conversion helpers for the Neo-Geo pixel output stage.
package neo_video_pkg;

    localparam int PAL_DARK_BIT = 15;
    localparam int MAX_COLOR_W  = 11;

    localparam int R_NIB_LO  = 8;
    localparam int G_NIB_LO  = 4;
    localparam int B_NIB_LO  = 0;
    localparam int R_LSB_BIT = 14;
    localparam int G_LSB_BIT = 13;
    localparam int B_LSB_BIT = 12;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0};

    // Channel index 0/1/2 = R/G/B
    function automatic int chan_nib_lo(input int ch);
        case (ch)
            0:       return R_NIB_LO;
            1:       return G_NIB_LO;
            default: return B_NIB_LO;
        endcase
    endfunction

    function automatic int chan_lsb_bit(input int ch);
        case (ch)
            0:       return R_LSB_BIT;
            1:       return G_LSB_BIT;
            default: return B_LSB_BIT;
        endcase
    endfunction

    function automatic logic [5:0] pal_to_c6(input logic [3:0] nibble, input logic lsb,
                                             input logic dark);
        logic [6:0] diff;
        diff = {1'b0, nibble, lsb, nibble[3]} - {6'd0, dark};
        return diff[6] ? 6'd0 : diff[5:0];
    endfunction

    // Replicates the upper c6 bits into the extra LSBs so full scale stays full scale
    function automatic logic [MAX_COLOR_W-1:0] expand_c6(input logic [5:0] c6, input int width);
        logic [MAX_COLOR_W-1:0] hi;
        logic [MAX_COLOR_W-1:0] lo;
        hi = {5'd0, c6} << (width - 6);
        lo = {6'd0, c6[4:0]} >> (MAX_COLOR_W - width);
        return hi | lo;
    endfunction

endpackage

// File: rtl/neo_color_chan.sv
// One colour channel: palette nibble to COLOR_W intensity with shadow and blank, registered.
module neo_color_chan #(
    parameter int COLOR_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_en,
    input  logic [3:0]         nibble,
    input  logic               lsb,
    input  logic               dark,
    input  logic               shadow,
    input  logic               blank,
    output logic [COLOR_W-1:0] color
);
    import neo_video_pkg::*;

    logic [COLOR_W-1:0] conv;
    logic [COLOR_W-1:0] color_d;
    logic [COLOR_W-1:0] color_q;

    always_comb begin
        conv    = COLOR_W'(expand_c6(pal_to_c6(nibble, lsb, dark), COLOR_W));
        color_d = color_q;
        if (clk_en) begin
            if (blank) begin
                color_d = '0;
            end else if (shadow) begin
                color_d = conv >> 1;
            end else begin
                color_d = conv;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_q <= '0;
        end else begin
            color_q <= color_d;
        end
    end

    assign color = color_q;

endmodule

// File: rtl/neo_video_out.sv
// Neo-Geo pixel output stage: palette to RGB pipeline, latency-matched syncs/DE,
// and beam position / line length counters.
module neo_video_out #(
    parameter int COLOR_W     = 8,
    parameter int PIPE_STAGES = 1,
    parameter int POS_W       = 9
) (
    input  logic               CLK,
    input  logic               nRESET,
    input  logic               CLK_EN_PIX,
    input  logic [15:0]        PAL_DATA,
    input  logic               SHADOW,
    input  logic               BLANK,
    input  logic               HSYNC_IN,
    input  logic               VSYNC_IN,
    output logic [COLOR_W-1:0] RED,
    output logic [COLOR_W-1:0] GREEN,
    output logic [COLOR_W-1:0] BLUE,
    output logic               HSYNC,
    output logic               VSYNC,
    output logic               DE,
    output logic [POS_W-1:0]   HPOS,
    output logic [POS_W-1:0]   VPOS,
    output logic [POS_W-1:0]   LINE_PIXELS
);
    import neo_video_pkg::*;

    generate
        if (COLOR_W < 6 || COLOR_W > 11) begin : g_bad_color_w
            $error("neo_video_out: COLOR_W must be 6..11");
        end
        if (PIPE_STAGES < 0 || PIPE_STAGES > 4) begin : g_bad_pipe
            $error("neo_video_out: PIPE_STAGES must be 0..4");
        end
    endgenerate

    localparam int BUS_W = 3 * COLOR_W + 3;
    localparam logic [BUS_W-1:0] BUS_IDLE = {{(3 * COLOR_W){1'b0}}, CTL_IDLE};

    logic [15:0]      pal1_d, pal1_q;
    logic             shadow1_d, shadow1_q, blank1_d, blank1_q;
    logic             hs1_d, hs1_q, vs1_d, vs1_q;
    logic             hs_prev_d, hs_prev_q, vs_prev_d, vs_prev_q;
    ctl_t             ctl2_d, ctl2_q;
    logic [POS_W-1:0] hpos_d, hpos_q, vpos_d, vpos_q, lpix_d, lpix_q;
    logic             hs_fall, vs_fall;

    logic [COLOR_W-1:0] chan_c [3];
    logic [BUS_W-1:0]   stage_w [PIPE_STAGES+1];

    always_comb begin
        pal1_d    = pal1_q;
        shadow1_d = shadow1_q;
        blank1_d  = blank1_q;
        hs1_d     = hs1_q;
        vs1_d     = vs1_q;
        hs_prev_d = hs_prev_q;
        vs_prev_d = vs_prev_q;
        ctl2_d    = ctl2_q;
        if (CLK_EN_PIX) begin
            pal1_d       = PAL_DATA;
            shadow1_d    = SHADOW;
            blank1_d     = BLANK;
            hs1_d        = HSYNC_IN;
            vs1_d        = VSYNC_IN;
            hs_prev_d    = hs1_q;
            vs_prev_d    = vs1_q;
            ctl2_d.hsync = hs1_q;
            ctl2_d.vsync = vs1_q;
            ctl2_d.de    = ~blank1_q;
        end
    end

    // Edges are taken from the stage-1 samples so counters stay aligned with the data path
    assign hs_fall = hs_prev_q & ~hs1_q;
    assign vs_fall = vs_prev_q & ~vs1_q;

    always_comb begin
        hpos_d = hpos_q;
        vpos_d = vpos_q;
        lpix_d = lpix_q;
        if (CLK_EN_PIX) begin
            if (hs_fall) begin
                lpix_d = hpos_q + 1'b1;
                hpos_d = '0;
                vpos_d = (&vpos_q) ? vpos_q : vpos_q + 1'b1;
            end else begin
                hpos_d = (&hpos_q) ? hpos_q : hpos_q + 1'b1;
            end
            if (vs_fall) begin
                vpos_d = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            pal1_q    <= '0;
            shadow1_q <= 1'b0;
            blank1_q  <= 1'b1;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            hs_prev_q <= 1'b1;
            vs_prev_q <= 1'b1;
            ctl2_q    <= CTL_IDLE;
            hpos_q    <= '0;
            vpos_q    <= '0;
            lpix_q    <= '0;
        end else begin
            pal1_q    <= pal1_d;
            shadow1_q <= shadow1_d;
            blank1_q  <= blank1_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            hs_prev_q <= hs_prev_d;
            vs_prev_q <= vs_prev_d;
            ctl2_q    <= ctl2_d;
            hpos_q    <= hpos_d;
            vpos_q    <= vpos_d;
            lpix_q    <= lpix_d;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        localparam int NIB_LO  = chan_nib_lo(gi);
        localparam int LSB_BIT = chan_lsb_bit(gi);
        neo_color_chan #(.COLOR_W(COLOR_W)) u_chan (
            .clk    (CLK),
            .rst_n  (nRESET),
            .clk_en (CLK_EN_PIX),
            .nibble (pal1_q[NIB_LO +: 4]),
            .lsb    (pal1_q[LSB_BIT]),
            .dark   (pal1_q[PAL_DARK_BIT]),
            .shadow (shadow1_q),
            .blank  (blank1_q),
            .color  (chan_c[gi])
        );
    end

    assign stage_w[0] = {chan_c[0], chan_c[1], chan_c[2], ctl2_q};

    for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_pipe
        logic [BUS_W-1:0] pipe_d;
        logic [BUS_W-1:0] pipe_q;

        always_comb begin
            pipe_d = pipe_q;
            if (CLK_EN_PIX) begin
                pipe_d = stage_w[gi];
            end
        end

        always_ff @(posedge CLK or negedge nRESET) begin
            if (!nRESET) begin
                pipe_q <= BUS_IDLE;
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign stage_w[gi+1] = pipe_q;
    end

    assign {RED, GREEN, BLUE, HSYNC, VSYNC, DE} = stage_w[PIPE_STAGES];
    assign HPOS        = hpos_q;
    assign VPOS        = vpos_q;
    assign LINE_PIXELS = lpix_q;

endmodule

// File: tb/tb_neo_video_out.sv
// Scoreboard bench for neo_video_out: three parameterisations driven in parallel,
// checked against an arithmetic reference model of the palette and counter rules.
module tb_neo_video_out;

    typedef struct {
        int r;
        int g;
        int b;
        int hs;
        int vs;
        int de;
    } exp_t;

    localparam int NDUT = 3;
    localparam int WID [NDUT] = '{8, 6, 10};
    localparam int LAT [NDUT] = '{3, 2, 4};

    logic        CLK = 1'b0;
    logic        nRESET = 1'b0;
    logic        CLK_EN_PIX = 1'b0;
    logic [15:0] PAL_DATA = 16'h0000;
    logic        SHADOW = 1'b0;
    logic        BLANK = 1'b0;
    logic        HSYNC_IN = 1'b1;
    logic        VSYNC_IN = 1'b1;

    logic [7:0]  r_a, g_a, b_a;
    logic [5:0]  r_b, g_b, b_b;
    logic [9:0]  r_c, g_c, b_c;
    logic        hs_a, vs_a, de_a, hs_b, vs_b, de_b, hs_c, vs_c, de_c;
    logic [8:0]  hp_a, vp_a, lp_a, hp_b, vp_b, lp_b, hp_c, vp_c, lp_c;

    neo_video_out #(.COLOR_W(8), .PIPE_STAGES(1), .POS_W(9)) dut_a (
        .CLK(CLK), .nRESET(nRESET), .CLK_EN_PIX(CLK_EN_PIX), .PAL_DATA(PAL_DATA),
        .SHADOW(SHADOW), .BLANK(BLANK), .HSYNC_IN(HSYNC_IN), .VSYNC_IN(VSYNC_IN),
        .RED(r_a), .GREEN(g_a), .BLUE(b_a), .HSYNC(hs_a), .VSYNC(vs_a), .DE(de_a),
        .HPOS(hp_a), .VPOS(vp_a), .LINE_PIXELS(lp_a));

    neo_video_out #(.COLOR_W(6), .PIPE_STAGES(0), .POS_W(9)) dut_b (
        .CLK(CLK), .nRESET(nRESET), .CLK_EN_PIX(CLK_EN_PIX), .PAL_DATA(PAL_DATA),
        .SHADOW(SHADOW), .BLANK(BLANK), .HSYNC_IN(HSYNC_IN), .VSYNC_IN(VSYNC_IN),
        .RED(r_b), .GREEN(g_b), .BLUE(b_b), .HSYNC(hs_b), .VSYNC(vs_b), .DE(de_b),
        .HPOS(hp_b), .VPOS(vp_b), .LINE_PIXELS(lp_b));

    neo_video_out #(.COLOR_W(10), .PIPE_STAGES(2), .POS_W(9)) dut_c (
        .CLK(CLK), .nRESET(nRESET), .CLK_EN_PIX(CLK_EN_PIX), .PAL_DATA(PAL_DATA),
        .SHADOW(SHADOW), .BLANK(BLANK), .HSYNC_IN(HSYNC_IN), .VSYNC_IN(VSYNC_IN),
        .RED(r_c), .GREEN(g_c), .BLUE(b_c), .HSYNC(hs_c), .VSYNC(vs_c), .DE(de_c),
        .HPOS(hp_c), .VPOS(vp_c), .LINE_PIXELS(lp_c));

    always #5 CLK = ~CLK;

    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;
    exp_t sbq [NDUT][$];
    exp_t cur [NDUT];
    // Counter reference: last two enabled HSYNC_IN/VSYNC_IN samples, newest in *_d1
    int   m_hpos, m_vpos, m_lpix, hs_d1, hs_d2, vs_d1, vs_d2;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Intensity from the palette rules in plain arithmetic
    function automatic int chan_ref(input int pal, input int nib_lo, input int lsb_bit,
                                    input int sh, input int bl, input int w);
        int nib, v, e;
        if (bl != 0) return 0;
        nib = (pal >> nib_lo) % 16;
        v = nib * 4 + ((pal >> lsb_bit) % 2) * 2 + nib / 8 - (pal >> 15) % 2;
        if (v < 0) v = 0;
        e = v * (1 << (w - 6)) + (v % 32) / (1 << (11 - w));
        if (sh != 0) e = e / 2;
        return e;
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e.r = 0; e.g = 0; e.b = 0; e.hs = 1; e.vs = 1; e.de = 0;
        return e;
    endfunction

    task automatic sb_init();
        for (int k = 0; k < NDUT; k++) begin
            sbq[k].delete();
            cur[k] = idle_exp();
            for (int j = 0; j < LAT[k] - 1; j++) sbq[k].push_back(idle_exp());
        end
        m_hpos = 0; m_vpos = 0; m_lpix = 0;
        hs_d1 = 1; hs_d2 = 1; vs_d1 = 1; vs_d2 = 1;
    endtask

    task automatic read_out(input int k, output int r, output int g, output int b,
                            output int hs, output int vs, output int de,
                            output int hp, output int vp, output int lp);
        case (k)
            0: begin r = r_a; g = g_a; b = b_a; hs = hs_a; vs = vs_a; de = de_a;
                     hp = hp_a; vp = vp_a; lp = lp_a; end
            1: begin r = r_b; g = g_b; b = b_b; hs = hs_b; vs = vs_b; de = de_b;
                     hp = hp_b; vp = vp_b; lp = lp_b; end
            default: begin r = r_c; g = g_c; b = b_c; hs = hs_c; vs = vs_c; de = de_c;
                     hp = hp_c; vp = vp_c; lp = lp_c; end
        endcase
    endtask

    task automatic check_idle(input string tag);
        int r, g, b, hs, vs, de, hp, vp, lp;
        for (int k = 0; k < NDUT; k++) begin
            read_out(k, r, g, b, hs, vs, de, hp, vp, lp);
            chk($sformatf("%s_rgb_d%0d", tag, k), r + g + b, 0);
            chk($sformatf("%s_sync_d%0d", tag, k), hs * 2 + vs, 3);
            chk($sformatf("%s_de_d%0d", tag, k), de, 0);
            chk($sformatf("%s_cnt_d%0d", tag, k), hp + vp + lp, 0);
        end
    endtask

    // Stimulus side: issue one pixel enable and queue its expected response
    task automatic do_enable(input int pal, input int sh, input int bl, input int hs,
                             input int vs, input int idle);
        exp_t e;
        @(negedge CLK);
        PAL_DATA = 16'(pal); SHADOW = sh[0]; BLANK = bl[0];
        HSYNC_IN = hs[0]; VSYNC_IN = vs[0]; CLK_EN_PIX = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            e.r  = chan_ref(pal, 8, 14, sh, bl, WID[k]);
            e.g  = chan_ref(pal, 4, 13, sh, bl, WID[k]);
            e.b  = chan_ref(pal, 0, 12, sh, bl, WID[k]);
            e.hs = hs; e.vs = vs; e.de = (bl != 0) ? 0 : 1;
            sbq[k].push_back(e);
        end
        $display("tx pal=%04h sh=%0d bl=%0d hs=%0d vs=%0d", pal, sh, bl, hs, vs);
        @(negedge CLK);
        CLK_EN_PIX = 1'b0;
        repeat (idle) @(negedge CLK);
    endtask

    // Monitor: pops one expectation per enable, compares every cycle (covers hold)
    initial begin
        bit en;
        int hin, vin, r, g, b, hs, vs, de, hp, vp, lp;
        bit hedge, vedge;
        forever begin
            @(posedge CLK);
            en = CLK_EN_PIX; hin = HSYNC_IN; vin = VSYNC_IN;
            if (mon_on) begin
                if (en) begin
                    for (int k = 0; k < NDUT; k++) begin
                        if (sbq[k].size() == 0) begin
                            chk($sformatf("sb_underflow_d%0d", k), 0, 1);
                        end else begin
                            cur[k] = sbq[k].pop_front();
                        end
                    end
                    hedge = (hs_d2 == 1 && hs_d1 == 0);
                    vedge = (vs_d2 == 1 && vs_d1 == 0);
                    if (hedge) begin
                        m_lpix = (m_hpos + 1) % 512;
                        m_hpos = 0;
                        if (m_vpos < 511) m_vpos++;
                    end else if (m_hpos < 511) begin
                        m_hpos++;
                    end
                    if (vedge) m_vpos = 0;
                    hs_d2 = hs_d1; hs_d1 = hin;
                    vs_d2 = vs_d1; vs_d1 = vin;
                end
                #1;
                for (int k = 0; k < NDUT; k++) begin
                    read_out(k, r, g, b, hs, vs, de, hp, vp, lp);
                    chk($sformatf("red_d%0d", k), r, cur[k].r);
                    chk($sformatf("green_d%0d", k), g, cur[k].g);
                    chk($sformatf("blue_d%0d", k), b, cur[k].b);
                    chk($sformatf("hsync_d%0d", k), hs, cur[k].hs);
                    chk($sformatf("vsync_d%0d", k), vs, cur[k].vs);
                    chk($sformatf("de_d%0d", k), de, cur[k].de);
                    chk($sformatf("hpos_d%0d", k), hp, m_hpos);
                    chk($sformatf("vpos_d%0d", k), vp, m_vpos);
                    chk($sformatf("line_pixels_d%0d", k), lp, m_lpix);
                end
            end
        end
    end

    initial begin
        int hs, vs;
        sb_init();
        repeat (3) @(negedge CLK);
        check_idle("reset");
        @(negedge CLK);
        nRESET = 1'b1;
        sb_init();
        mon_on = 1'b1;

        do_enable(16'h0F00, 0, 0, 1, 1, 4);
        do_enable(16'h7FFF, 0, 0, 1, 1, 1);
        do_enable(16'hFFFF, 0, 0, 1, 1, 1);
        do_enable(16'h8000, 0, 0, 1, 1, 1);
        do_enable(16'h7FFF, 1, 0, 1, 1, 1);
        do_enable(16'h7FFF, 1, 1, 1, 1, 1);
        for (int i = 0; i < 6; i++) do_enable(16'h0000, 0, 0, 1, 1, 3);

        // Three lines of 384 enables; VSYNC falls together with HSYNC at line two
        for (int n = 0; n < 3 * 384; n++) begin
            hs = (n % 384 == 0) ? 0 : 1;
            vs = (n == 384) ? 0 : 1;
            do_enable(int'($urandom_range(0, 65535)), ($urandom % 4 == 0) ? 1 : 0,
                      ($urandom % 8 == 0) ? 1 : 0, hs, vs, int'($urandom_range(0, 2)));
        end
        do_enable(16'h1234, 0, 0, 0, 1, 0);
        repeat (3) do_enable(16'h4321, 0, 0, 1, 1, 0);
        chk("line_pixels_384", int'(lp_a), 384);

        for (int n = 0; n < 600; n++) begin
            do_enable(int'($urandom_range(0, 65535)), 0, 0, 1, 1, 0);
        end
        chk("hpos_saturated", int'(hp_a), 511);

        // Asynchronous reset in the middle of a clock period
        @(posedge CLK);
        #3;
        mon_on = 1'b0;
        nRESET = 1'b0;
        #1;
        check_idle("async_reset");
        repeat (2) @(negedge CLK);
        nRESET = 1'b1;
        sb_init();
        mon_on = 1'b1;
        do_enable(16'h0F00, 0, 0, 1, 1, 2);
        for (int n = 0; n < 20; n++) begin
            do_enable(int'($urandom_range(0, 65535)), ($urandom % 3 == 0) ? 1 : 0,
                      ($urandom % 5 == 0) ? 1 : 0, ($urandom % 7 == 0) ? 0 : 1, 1,
                      int'($urandom_range(0, 3)));
        end
        repeat (4) @(negedge CLK);
        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
